sao_stream_filter: RTL
======================

Name: sao_stream_filter

Overview:
Parametrised streaming SAO filter. It accepts reconstructed pixels LCU-by-LCU, in raster order inside each LCU. It applies band offset or one of four edge-offset classes, and writes filtered pixels to an external frame SRAM port. It generalises the existing SAO engine in bit depth, frame size and LCU size, and adds diagonal EO classes and back-to-back frame processing.

Parameters:
BIT_DEPTH, 8, pixel width (8..10)
OFFSET_W, 4, width of each signed offset
IMG_W, 128, frame width in pixels
IMG_H, 128, frame height in pixels
MAX_LCU, 64, largest supported LCU edge; sizes line buffer
ADDR_W, 14, SRAM address width, clog2(IMG_W*IMG_H)
LCU_IDX_W, 3, width of lcu_x/lcu_y

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_en  in  1  pixel valid
din  in  BIT_DEPTH  input pixel
sao_type  in  2  0 off, 1 band, 2 edge, 3 reserved (treated as off)
sao_band_pos  in  5  first band of the 4 offset bands
sao_eo_class  in  2  0 horizontal, 1 vertical, 2 135deg, 3 45deg
sao_offset  in  4*OFFSET_W  offset i at [i*OFFSET_W +: OFFSET_W], two's complement
lcu_x  in  LCU_IDX_W  LCU column index
lcu_y  in  LCU_IDX_W  LCU row index
lcu_size  in  2  0=16, 1=32, 2=64, 3 reserved (treated as 64); must be <= MAX_LCU
busy  out  1  block cannot accept a pixel
finish  out  1  one-cycle pulse at end of frame
sram_we  out  1  write strobe
sram_addr  out  ADDR_W  write address
sram_wdata  out  BIT_DEPTH  filtered pixel

Behaviour:
- Reset (async, active-high): busy, finish, sram_we, sram_addr, sram_wdata = 0; FSM to IDLE; line buffer contents don't-care; a partial LCU in progress is discarded.
- Acceptance: a pixel is accepted on a rising edge with in_en=1 and busy=0. in_en held high while busy=1 is ignored.
- N is the LCU edge from lcu_size. Pixel index k = r*N+c.
- On acceptance of k=0, the block samples sao_type, band_pos, eo_class, offset, lcu_x, lcu_y and lcu_size, and holds them for the whole LCU. Changes to these inputs at k>0 are ignored.
- FSM:
  - IDLE -> RUN on acceptance of k=0.
  - RUN -> DRAIN on acceptance of k=N*N-1.
  - DRAIN lasts exactly N+1 cycles, then returns to IDLE.
  - busy = 1 only in DRAIN. busy rises the cycle after k=N*N-1 is accepted and falls after the last drain write.
- Window: a shift-register line buffer of 2*MAX_LCU+2 pixels gives the 3x3 neighbourhood.
- Output order and latency: pixel k is written (sram_we=1 for one cycle, registered) in the cycle after acceptance of pixel k+N+1. Remaining pixels N*N-N-1 .. N*N-1 are written on consecutive DRAIN cycles. Writes are always in raster order. Input gaps produce write gaps.
- Address: sram_addr = (lcu_y*N + r)*IMG_W + lcu_x*N + c.
- Type off: sram_wdata = input pixel.
- Band offset:
  - band = p >> (BIT_DEPTH-5); idx = (band - band_pos) mod 32.
  - If idx < 4, apply offset idx; otherwise pixel unchanged.
  - Wrap-around is required: band_pos=30 covers bands 30, 31, 0, 1.
- Edge offset: neighbours a, b:
  - class 0: left, right
  - class 1: up, down
  - class 2: up-left, down-right
  - class 3: up-right, down-left
- Edge categories:
  - cat1: p<a and p<b -> offset0
  - cat2: (p<a and p==b) or (p==a and p<b) -> offset1
  - cat3: (p>a and p==b) or (p==a and p>b) -> offset2
  - cat4: p>a and p>b -> offset3
  - otherwise unchanged
- LCU boundary: if a or b lies outside the current LCU, the pixel is unchanged. Class 0 affects columns 0 and N-1; class 1 affects rows 0 and N-1; classes 2 and 3 affect both.
- Arithmetic: sign-extend the offset, add in BIT_DEPTH+2 bits, clip to [0, 2^BIT_DEPTH-1].
- finish: pulses 1 cycle, coincident with busy falling, after the final write of the LCU with lcu_x = IMG_W/N-1 and lcu_y = IMG_H/N-1. The block then accepts a new frame with no reset.

Test Plan:
- Band, BIT_DEPTH=8, N=32, band_pos=4, offsets {+3,-2,+7,-8}: pixel 35 (band 4) -> 38; pixel 60 (band 7) -> 52; pixel 64 (band 8) -> 64; pixel 5 with offset -8 configured -> clipped result >= 0.
- Band wrap, band_pos=30, offset1=+7, pixel 250 (band 31) -> 255 (clip from 257); pixel 8 (band 1) gets offset3.
- EO class 0: row ...10,5,10... -> centre 5 becomes 5+offset0; column 0 and column 31 pixels unchanged.
- EO classes 2/3: single local maximum 200 in an interior flat field of 100, offset3=-4 -> 196. Same max placed in row 0 -> unchanged.
- Handshake: full 16x16 LCU stream with random in_en gaps -> writes in raster order. busy is high exactly 17 cycles starting the cycle after pixel 255 is accepted. in_en held high during busy is not consumed.
- Full 128x128 frame of 32x32 LCUs, then a second frame; reset asserted mid-LCU on a third pass -> finish pulses once per complete frame. SRAM matches the golden model. After reset, busy/sram_we are 0 and the next LCU restarts at k=0.

Source files
------------

// File: rtl/sao_stream_filter.sv
// Streaming SAO filter: takes reconstructed pixels LCU by LCU in raster order, applies
// band or edge offset from a 3x3 window, and writes filtered pixels to a frame SRAM port.
module sao_stream_filter #(
  parameter int BIT_DEPTH = 8,
  parameter int OFFSET_W  = 4,
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int MAX_LCU   = 64,
  parameter int ADDR_W    = 14,
  parameter int LCU_IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic [BIT_DEPTH-1:0]    din,
  input  logic [1:0]              sao_type,
  input  logic [4:0]              sao_band_pos,
  input  logic [1:0]              sao_eo_class,
  input  logic [4*OFFSET_W-1:0]   sao_offset,
  input  logic [LCU_IDX_W-1:0]    lcu_x,
  input  logic [LCU_IDX_W-1:0]    lcu_y,
  input  logic [1:0]              lcu_size,
  output logic                    busy,
  output logic                    finish,
  output logic                    sram_we,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [BIT_DEPTH-1:0]    sram_wdata
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int NW     = $clog2(MAX_LCU) + 1;
  localparam int KW     = $clog2(MAX_LCU * MAX_LCU) + 1;
  localparam int SR_LEN = 2 * MAX_LCU + 2;
  localparam int IDX_W  = $clog2(SR_LEN);
  localparam int SW     = BIT_DEPTH + 2;

  logic [1:0]            state;
  logic [KW-1:0]         k_cnt;
  logic [NW-1:0]         drain_cnt, out_r, out_c, n_cur;
  logic [1:0]            cfg_type, cfg_eo, cfg_size;
  logic [4:0]            cfg_band;
  logic [4*OFFSET_W-1:0] cfg_off;
  logic [LCU_IDX_W-1:0]  cfg_x, cfg_y;
  logic [BIT_DEPTH-1:0]  sr [SR_LEN];

  logic                  accept, step, write_now, k_last, last_lcu;
  logic [BIT_DEPTH-1:0]  in_pix, p, a, b, filt;
  logic [IDX_W-1:0]      i_n, i_2n;
  logic [KW-1:0]         nn_m1;
  logic [ADDR_W-1:0]     addr;

  assign busy   = (state == S_DRAIN);
  assign accept = in_en && !busy;
  assign step   = accept || busy;
  // Drain cycles shift in dummy pixels; they only ever land outside the LCU.
  assign in_pix = accept ? din : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    n_cur = NW'(64);
    case (cfg_size)
      2'd0:    n_cur = NW'(16);
      2'd1:    n_cur = NW'(32);
      default: n_cur = NW'(64);
    endcase
  end

  assign nn_m1     = KW'(n_cur) * KW'(n_cur) - KW'(1);
  assign k_last    = (k_cnt == nn_m1);
  assign write_now = (state == S_RUN && accept && k_cnt > KW'(n_cur)) || busy;
  assign last_lcu  = ((int'(cfg_x) + 1) * int'(n_cur) == IMG_W) &&
                     ((int'(cfg_y) + 1) * int'(n_cur) == IMG_H);
  assign addr = (ADDR_W'(cfg_y) * ADDR_W'(n_cur) + ADDR_W'(out_r)) * ADDR_W'(IMG_W)
              + ADDR_W'(cfg_x) * ADDR_W'(n_cur) + ADDR_W'(out_c);

  // The pixel being written is N+1 behind the incoming one, so sr[N] is the centre.
  assign i_n  = IDX_W'(n_cur);
  assign i_2n = i_n << 1;
  assign p    = sr[i_n];

  logic                 apply, oob, c_first, c_last, r_first, r_last;
  logic [1:0]           sel;
  logic [4:0]           bidx;
  logic [OFFSET_W-1:0]  off_sel;
  logic [SW-1:0]        sum;

  assign c_first = (out_c == '0);
  assign c_last  = (out_c == n_cur - NW'(1));
  assign r_first = (out_r == '0);
  assign r_last  = (out_r == n_cur - NW'(1));

  always_comb begin
    apply = 1'b0;
    sel   = 2'd0;
    a     = sr[i_n + IDX_W'(1)];
    b     = sr[i_n - IDX_W'(1)];
    oob   = c_first || c_last;
    bidx  = p[BIT_DEPTH-1 -: 5] - cfg_band;
    case (cfg_eo)
      2'd1: begin a = sr[i_2n];              b = sr[0];  oob = r_first || r_last; end
      2'd2: begin a = sr[i_2n + IDX_W'(1)];  b = in_pix; oob = r_first || r_last || c_first || c_last; end
      2'd3: begin a = sr[i_2n - IDX_W'(1)];  b = sr[1];  oob = r_first || r_last || c_first || c_last; end
      default: ;
    endcase
    case (cfg_type)
      2'd1: begin
        apply = (bidx < 5'd4);
        sel   = bidx[1:0];
      end
      2'd2: begin
        if (!oob) begin
          if (p < a && p < b) begin
            apply = 1'b1; sel = 2'd0;
          end else if ((p < a && p == b) || (p == a && p < b)) begin
            apply = 1'b1; sel = 2'd1;
          end else if ((p > a && p == b) || (p == a && p > b)) begin
            apply = 1'b1; sel = 2'd2;
          end else if (p > a && p > b) begin
            apply = 1'b1; sel = 2'd3;
          end
        end
      end
      default: ;
    endcase
    off_sel = cfg_off[sel*OFFSET_W +: OFFSET_W];
    sum     = {2'b00, p} + {{(SW-OFFSET_W){off_sel[OFFSET_W-1]}}, off_sel};
    if (!apply)           filt = p;
    else if (sum[SW-1])   filt = '0;
    else if (|sum[SW-2:BIT_DEPTH]) filt = '1;
    else                  filt = sum[BIT_DEPTH-1:0];
  end

  // NOTE: the line buffer is pure datapath storage and is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (step) begin
      sr[0] <= in_pix;
      for (int i = 1; i < SR_LEN; i++) sr[i] <= sr[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      k_cnt      <= '0;
      drain_cnt  <= '0;
      out_r      <= '0;
      out_c      <= '0;
      cfg_type   <= '0;
      cfg_eo     <= '0;
      cfg_size   <= '0;
      cfg_band   <= '0;
      cfg_off    <= '0;
      cfg_x      <= '0;
      cfg_y      <= '0;
      finish     <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_we <= write_now;
      finish  <= 1'b0;
      if (write_now) begin
        sram_addr  <= addr;
        sram_wdata <= filt;
        if (c_last) begin
          out_c <= '0;
          out_r <= out_r + NW'(1);
        end else begin
          out_c <= out_c + NW'(1);
        end
      end
      case (state)
        S_IDLE: if (accept) begin
          cfg_type <= sao_type;
          cfg_band <= sao_band_pos;
          cfg_eo   <= sao_eo_class;
          cfg_off  <= sao_offset;
          cfg_x    <= lcu_x;
          cfg_y    <= lcu_y;
          cfg_size <= lcu_size;
          k_cnt    <= KW'(1);
          out_r    <= '0;
          out_c    <= '0;
          state    <= S_RUN;
        end
        S_RUN: if (accept) begin
          k_cnt <= k_cnt + KW'(1);
          if (k_last) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + NW'(1);
          if (drain_cnt == n_cur) begin
            state  <= S_IDLE;
            finish <= last_lcu;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
